// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op encodings, FSM states, default width.
package muldiv_pkg;

  localparam int WIDTH_DEF = 32;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MFHI  = 3'b100;
  localparam logic [2:0] OP_MFLO  = 3'b101;
  localparam logic [2:0] OP_MTHI  = 3'b110;
  localparam logic [2:0] OP_MTLO  = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    ITER = 2'd2,
    FIX  = 2'd3
  } state_t;

endpackage

// File: rtl/muldiv_unit.sv
// Multicycle HI/LO multiply/divide unit: shift-add multiply and restoring divide, one bit per cycle.
// state | meaning
// IDLE  | waiting; accepts mult/div, performs mthi/mtlo writes
// PREP  | take operand magnitudes, record result/remainder signs, load counter
// ITER  | one multiply/divide bit per cycle, WIDTH cycles
// FIX   | apply signs, write HI/LO
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       alucontrol,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] mfresult,
  output logic             busy,
  output logic             done,
  output logic             stall
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_opnd;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [2*WIDTH-1:0] r_acc;
  logic               r_signed;
  logic               r_is_div;
  logic               r_neg_res;
  logic               r_neg_rem;
  logic               r_dbz;
  logic               r_done;

  logic [2:0]         w_op;
  logic               w_ext;
  logic               w_accept;
  logic               w_mt;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH:0]     w_msum;
  logic [2*WIDTH-1:0] w_mul_acc;
  logic [WIDTH:0]     w_rem2;
  logic               w_borrow;
  logic [WIDTH-1:0]   w_trial;
  logic               w_ge;
  logic [2*WIDTH-1:0] w_div_acc;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_fix_hi;
  logic [WIDTH-1:0]   w_fix_lo;

  assign w_op     = alucontrol[2:0];
  assign w_ext    = start & alucontrol[3];
  assign w_accept = (r_state == IDLE) & w_ext &
                    ((w_op == OP_MULT) | (w_op == OP_MULTU) | (w_op == OP_DIV) | (w_op == OP_DIVU));
  assign w_mt     = (r_state == IDLE) & w_ext & ((w_op == OP_MTHI) | (w_op == OP_MTLO));

  assign busy     = (r_state != IDLE);
  assign done     = r_done;
  assign stall    = busy & w_ext;
  assign hi       = r_hi;
  assign lo       = r_lo;
  assign mfresult = (w_op == OP_MFHI) ? r_hi : r_lo;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = PREP;
      PREP:    w_state_nxt = ITER;
      ITER:    if (r_cnt == CW'(1)) w_state_nxt = FIX;
      FIX:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_a_mag = (r_signed & r_a[WIDTH-1]) ? -r_a : r_a;
  assign w_b_mag = (r_signed & r_b[WIDTH-1]) ? -r_b : r_b;

  // Multiply: acc = {partial product, remaining multiplier bits}; carry of the add is kept.
  assign w_msum    = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_opnd};
  assign w_mul_acc = r_acc[0] ? {w_msum, r_acc[WIDTH-1:1]} : {1'b0, r_acc[2*WIDTH-1:1]};

  // Divide: acc = {remainder, dividend/quotient}. A set top bit in the shifted remainder
  // already exceeds any divisor, so the trial subtract then always succeeds.
  assign w_rem2              = r_acc[2*WIDTH-1:WIDTH-1];
  assign {w_borrow, w_trial} = {1'b0, w_rem2[WIDTH-1:0]} - {1'b0, r_opnd};
  assign w_ge                = w_rem2[WIDTH] | ~w_borrow;
  assign w_div_acc           = w_ge ? {w_trial, r_acc[WIDTH-2:0], 1'b1}
                                    : {w_rem2[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};

  assign w_prod = r_neg_res ? -r_acc : r_acc;

  // Divide by zero yields an all-ones quotient unsigned-style; the remainder sign restores srca.
  always_comb begin
    w_fix_hi = w_prod[2*WIDTH-1:WIDTH];
    w_fix_lo = w_prod[WIDTH-1:0];
    if (r_is_div) begin
      w_fix_lo = (r_neg_res & ~r_dbz) ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
      w_fix_hi = r_neg_rem ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_opnd    <= '0;
      r_acc     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_signed  <= 1'b0;
      r_is_div  <= 1'b0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_dbz     <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= (r_state == FIX);
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_a      <= srca;
            r_b      <= srcb;
            r_signed <= (w_op == OP_MULT) | (w_op == OP_DIV);
            r_is_div <= (w_op == OP_DIV) | (w_op == OP_DIVU);
          end
          if (w_mt) begin
            if (w_op == OP_MTLO) r_lo <= srca;
            else                 r_hi <= srca;
          end
        end
        PREP: begin
          r_cnt     <= CW'(WIDTH);
          r_neg_res <= r_signed & (r_a[WIDTH-1] ^ r_b[WIDTH-1]);
          r_neg_rem <= r_signed & r_a[WIDTH-1];
          r_dbz     <= r_is_div & (r_b == '0);
          if (r_is_div) begin
            r_opnd <= w_b_mag;
            r_acc  <= {{WIDTH{1'b0}}, w_a_mag};
          end else begin
            r_opnd <= w_a_mag;
            r_acc  <= {{WIDTH{1'b0}}, w_b_mag};
          end
        end
        ITER: begin
          r_cnt <= r_cnt - CW'(1);
          r_acc <= r_is_div ? w_div_acc : w_mul_acc;
        end
        FIX: begin
          r_hi <= w_fix_hi;
          r_lo <= w_fix_lo;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed ops push expected HI/LO, a monitor checks on done.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  alucontrol;
  logic [31:0] srca, srcb;
  logic [31:0] hi, lo, mfresult;
  logic        busy, done, stall;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .alucontrol(alucontrol),
    .srca(srca), .srcb(srcb), .hi(hi), .lo(lo), .mfresult(mfresult),
    .busy(busy), .done(done), .stall(stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset && done) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 expected no pending op");
      end else begin
        e = exp_q.pop_front();
        chk({e.name, "_hi"}, hi, e.hi);
        chk({e.name, "_lo"}, lo, e.lo);
      end
    end
  end

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; alucontrol = {1'b1, op}; srca = a; srcb = b;
    @(negedge clk);
    start = 1'b0; alucontrol = 4'b0000;
  endtask

  task automatic do_op(input string nm, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
    int cyc;
    exp_q.push_back('{nm, ehi, elo});
    issue(op, a, b);
    cyc = 0;
    while (busy && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
    chk({nm, "_busy_cycles"}, 32'(cyc), 32'd34);
    chk({nm, "_done_pulse"}, {31'd0, done}, 32'd1);
    @(negedge clk);
    chk({nm, "_done_low"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int cyc;
    reset = 1'b1; start = 1'b0; alucontrol = 4'b0000; srca = '0; srcb = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);

    do_op("multu_max", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    do_op("mult_m3x5", 3'b000, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    do_op("div_m7d2",  3'b010, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    do_op("divu_7d2",  3'b011, 32'd7,         32'd2,         32'd1,         32'd3);
    do_op("divu_dbz",  3'b011, 32'd100,       32'd0,         32'h0000_0064, 32'hFFFF_FFFF);
    do_op("div_dbz",   3'b010, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF);
    do_op("div_ovf",   3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    do_op("div_7dm2",  3'b010, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);

    // mthi in IDLE writes at the next edge; mfhi reads it back combinationally
    issue(3'b110, 32'h0000_ABCD, 32'd0);
    chk("mthi_hi", hi, 32'h0000_ABCD);
    chk("mthi_lo_kept", lo, 32'hFFFF_FFFD);
    alucontrol = 4'b1100;
    #1 chk("mfhi", mfresult, 32'h0000_ABCD);

    // mtlo presented mid-sequence stalls until the unit is idle again
    exp_q.push_back('{"multu_64k", 32'h0000_0001, 32'h0000_0000});
    issue(3'b001, 32'h0001_0000, 32'h0001_0000);
    repeat (4) @(negedge clk);
    start = 1'b1; alucontrol = 4'b1111; srca = 32'h0000_1234;
    @(negedge clk);
    chk("mtlo_stall", {31'd0, stall}, 32'd1);
    chk("mtlo_lo_held", lo, 32'hFFFF_FFFD);
    cyc = 0;
    while (busy && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
    chk("mtlo_wait_bounded", {31'd0, busy}, 32'd0);
    @(negedge clk);
    start = 1'b0;
    chk("mtlo_lo", lo, 32'h0000_1234);
    chk("mtlo_hi_kept", hi, 32'h0000_0001);
    alucontrol = 4'b1101;
    #1 chk("mflo", mfresult, 32'h0000_1234);

    // reset in the middle of ITER aborts the sequence and clears HI/LO
    issue(3'b001, 32'd9, 32'd9);
    repeat (9) @(negedge clk);
    chk("abort_busy_before", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);

    do_op("multu_6x7", 3'b001, 32'd6, 32'd7, 32'd0, 32'd42);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
